// File: rtl/px_pkg.sv
// Shared definitions for the pixel readout receiver: frame phase encoding,
// default data width and Gray-code helpers.
package px_pkg;

  localparam int PX_DW = 8;

  typedef enum logic [2:0] {
    WAIT_ERASE = 3'd0,
    ERASE      = 3'd1,
    EXPOSE     = 3'd2,
    CONVERT    = 3'd3,
    READ       = 3'd4
  } phase_t;

  // Phase the sequencer is allowed to move to from p in a normal frame.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ERASE:   return EXPOSE;
      EXPOSE:  return CONVERT;
      CONVERT: return READ;
      READ:    return ERASE;
      default: return ERASE;
    endcase
  endfunction

  // Binary to Gray; callers zero-extend narrower values and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB down; zero upper bits stay zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/px_rx_fifo.sv
// Synchronous FIFO for the readout stream. Head entry is presented
// combinationally and forced to zero while empty, so the stream outputs read
// as zero after reset. A push into a full FIFO only succeeds when a pop frees
// a slot in the same cycle; the caller decides how to flag the drop.
module px_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr_reg];

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/px_readout_rx.sv
// Pixel readout receiver: follows the erase/expose/convert/read strobes,
// drives the ramp code during convert, captures one pixel word per row read
// slot and streams {row, data, last} out through a small FIFO.
// Optional build macro PX_GRAY_EN: ramp code leaves Gray-coded and pixel data
// arrives Gray-coded (converted back to binary before buffering).
module px_readout_rx
  import px_pkg::*;
#(
  parameter int DW         = PX_DW,
  parameter int NROWS      = 2,
  parameter int C_READ     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     erase,
  input  logic                     expose,
  input  logic                     convert,
  input  logic                     read,
  input  logic [DW-1:0]            px_data,
  output logic [DW-1:0]            dac_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(NROWS)-1:0] out_row,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     seq_err,
  output logic                     overflow
);

  localparam int RW = $clog2(NROWS);
  localparam int CW = $clog2(NROWS + 1);
  localparam int SW = (C_READ > 1) ? $clog2(C_READ) : 1;
  localparam int FW = RW + DW + 1;

  phase_t        state_reg, state_next, strobe_phase;
  logic [DW-1:0] ramp_reg, ramp_next;
  logic [SW-1:0] slot_reg, slot_next, cur_slot;
  logic [CW-1:0] row_reg, row_next, cur_row;
  logic          seq_err_reg, overflow_reg, frame_done_reg;
  logic [2:0]    n_hi;
  logic          err, push, last;
  logic [DW-1:0] px_val;
  logic [FW-1:0] fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty, pop;

  assign n_hi = {2'b0, erase} + {2'b0, expose} + {2'b0, convert} + {2'b0, read};

  // Slot/row position within the read phase; a fresh READ entry starts at zero.
  assign cur_slot = (state_reg == READ) ? slot_reg : '0;
  assign cur_row  = (state_reg == READ) ? row_reg  : '0;

`ifdef PX_GRAY_EN
  assign dac_code = DW'(bin2gray(32'(ramp_reg)));
  assign px_val   = DW'(gray2bin(32'(px_data)));
`else
  assign dac_code = ramp_reg;
  assign px_val   = px_data;
`endif

  // Phase tracking, protocol checking, ramp count and read-slot sampling.
  always_comb begin
    state_next   = state_reg;
    ramp_next    = ramp_reg;
    slot_next    = slot_reg;
    row_next     = row_reg;
    err          = 1'b0;
    push         = 1'b0;
    last         = 1'b0;
    strobe_phase = erase ? ERASE : expose ? EXPOSE : convert ? CONVERT : READ;

    if (n_hi > 3'd1) begin
      err        = 1'b1;
      state_next = WAIT_ERASE;
    end else if (n_hi == 3'd1) begin
      if (state_reg == WAIT_ERASE) begin
        if (erase) state_next = ERASE;
        else       err        = 1'b1;
      end else if (strobe_phase == state_reg || strobe_phase == next_phase(state_reg)) begin
        state_next = strobe_phase;
      end else begin
        err        = 1'b1;
        state_next = erase ? ERASE : WAIT_ERASE;
      end
    end

    // Read dropped before every row slot completed: short frame.
    if (state_reg == READ && !read && (slot_reg != '0 || row_reg != '0) &&
        row_reg != CW'(NROWS)) begin
      err = 1'b1;
    end

    if (state_next == ERASE && state_reg != ERASE) begin
      ramp_next = '0;
    end

    if (state_next == CONVERT && convert) begin
      if (state_reg != CONVERT)  ramp_next = '0;
      else if (ramp_reg != '1)   ramp_next = ramp_reg + 1'b1;
    end

    if (state_next == READ && read) begin
      if (cur_row == CW'(NROWS)) begin
        err = 1'b1;                      // read held past the last slot
      end else if (cur_slot == SW'(C_READ - 1)) begin
        push      = 1'b1;
        last      = (cur_row == CW'(NROWS - 1));
        slot_next = '0;
        row_next  = cur_row + 1'b1;
      end else begin
        slot_next = cur_slot + 1'b1;
        row_next  = cur_row;
      end
    end

    if (state_next != READ) begin
      slot_next = '0;
      row_next  = '0;
    end
  end

  // Sequential state, sticky flags and the frame-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= WAIT_ERASE;
      ramp_reg       <= '0;
      slot_reg       <= '0;
      row_reg        <= '0;
      seq_err_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ramp_reg       <= ramp_next;
      slot_reg       <= slot_next;
      row_reg        <= row_next;
      seq_err_reg    <= seq_err_reg | err;
      overflow_reg   <= overflow_reg | (push && fifo_full && !pop);
      frame_done_reg <= push && last;
    end
  end

  assign pop      = !fifo_empty && out_ready;
  assign fifo_din = {cur_row[RW-1:0], px_val, last};

  px_rx_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_row    = fifo_dout[FW-1 -: RW];
  assign out_data   = fifo_dout[DW:1];
  assign out_last   = fifo_dout[0];
  assign frame_done = frame_done_reg;
  assign seq_err    = seq_err_reg;
  assign overflow   = overflow_reg;

endmodule
